// File: rtl/dc_stream_pkg.sv
// Shared types and CSR layout constants for the multi-channel DC instruction streamer.
package dc_stream_pkg;

    typedef enum logic [1:0] {
        ITERS = 2'd0,
        LOOP  = 2'd1,
        ONCE  = 2'd2,
        RSVD  = 2'd3
    } dc_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } dc_state_e;

    localparam int ITER_LSB = 0;
    localparam int LEN_LSB  = 16;
    localparam int MODE_LSB = 28;

    // 32-bit CSR words needed to hold one instruction of the given width.
    function automatic int wpi(input int width);
        return (width + 31) / 32;
    endfunction

endpackage

// File: rtl/dc_stream_chan.sv
// One streamer channel: trigger edge detect, slot buffer capture, replay FSM and output register.
// Stream handshake: a beat transfers on a clock edge where o_valid & i_ready; while o_valid & !i_ready the beat is held unchanged, except that abort and a new stream both withdraw it.
module dc_stream_chan
    import dc_stream_pkg::*;
#(
    parameter  int INSN_WIDTH = 72,
    parameter  int ITER_WIDTH = 10,
    parameter  int DEPTH      = 20,
    localparam int WPI        = wpi(INSN_WIDTH),
    localparam int REGS       = DEPTH * WPI + 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [REGS*32-1:0]    i_regs,
    input  logic                  i_abort,
    input  logic                  i_ready,
    output logic                  o_valid,
    output logic [INSN_WIDTH-1:0] o_insn,
    output logic                  o_busy,
    output logic                  o_done,
    output dc_state_e             o_state
);

    localparam int LEN_W     = $clog2(DEPTH + 1);
    localparam int PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CTRL_BASE = DEPTH * WPI * 32;
    localparam int TRIG_BASE = (DEPTH * WPI + 1) * 32;

    logic [ITER_WIDTH-1:0] cfg_iters;
    logic [LEN_W-1:0]      cfg_len_raw;
    logic [LEN_W-1:0]      cfg_len;
    dc_mode_e              cfg_mode;
    logic                  cfg_empty;
    logic [PTR_W-1:0]      cfg_last;
    logic [ITER_WIDTH-1:0] cfg_left;
    logic                  unused_regs;

    assign cfg_iters   = i_regs[CTRL_BASE + ITER_LSB +: ITER_WIDTH];
    assign cfg_len_raw = i_regs[CTRL_BASE + LEN_LSB +: LEN_W];
    assign cfg_mode    = dc_mode_e'(i_regs[CTRL_BASE + MODE_LSB +: 2]);
    assign cfg_len     = (cfg_len_raw > LEN_W'(DEPTH)) ? LEN_W'(DEPTH) : cfg_len_raw;
    assign cfg_empty   = (cfg_len == '0) ||
                         ((cfg_iters == '0) && ((cfg_mode == ITERS) || (cfg_mode == RSVD)));
    assign cfg_last    = PTR_W'(cfg_len - LEN_W'(1));
    // LOOP never counts passes and ONCE is a single pass, so both start with one pass left.
    assign cfg_left    = ((cfg_mode == ONCE) || (cfg_mode == LOOP)) ? ITER_WIDTH'(1) : cfg_iters;
    assign unused_regs = ^i_regs;

    logic z1_q, z2_q, new_stream;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            z1_q <= 1'b0;
            z2_q <= 1'b0;
        end else begin
            z1_q <= (i_regs[TRIG_BASE +: 32] == 32'd0);
            z2_q <= z1_q;
        end
    end

    assign new_stream = z2_q & ~z1_q;

    dc_state_e             state_q, state_n;
    dc_mode_e              mode_q;
    logic [ITER_WIDTH-1:0] left_q;
    logic [PTR_W-1:0]      ptr_q, last_q;
    logic [INSN_WIDTH-1:0] slot_q [DEPTH];
    logic                  adv, at_last, final_pass, drain_accept;

    assign adv        = (state_q == RUN) && (!o_valid || i_ready);
    assign at_last    = (ptr_q == last_q);
    assign final_pass = (mode_q != LOOP) && (left_q == ITER_WIDTH'(1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        if (new_stream) begin
            state_n = cfg_empty ? IDLE : RUN;
        end else if (i_abort) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                RUN:     if (adv && at_last && final_pass) state_n = DRAIN;
                DRAIN:   if (i_ready) state_n = IDLE;
                default: state_n = state_q;
            endcase
        end
    end

    always_comb begin
        o_busy       = (state_q != IDLE);
        o_state      = state_q;
        drain_accept = (state_q == DRAIN) && i_ready && !i_abort && !new_stream;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_insn  <= '0;
            o_done  <= 1'b0;
            mode_q  <= ITERS;
            left_q  <= '0;
            ptr_q   <= '0;
            last_q  <= '0;
            for (int k = 0; k < DEPTH; k++) slot_q[k] <= '0;
        end else begin
            o_done <= 1'b0;
            if (new_stream) begin
                for (int k = 0; k < DEPTH; k++) slot_q[k] <= i_regs[k*WPI*32 +: INSN_WIDTH];
                mode_q  <= cfg_mode;
                left_q  <= cfg_left;
                last_q  <= cfg_last;
                ptr_q   <= '0;
                o_valid <= 1'b0;
                o_done  <= cfg_empty;
            end else if (i_abort) begin
                o_valid <= 1'b0;
            end else if (adv) begin
                o_valid <= 1'b1;
                o_insn  <= slot_q[ptr_q];
                if (at_last) begin
                    ptr_q <= '0;
                    if ((mode_q != LOOP) && (left_q != '0)) left_q <= left_q - ITER_WIDTH'(1);
                end else begin
                    ptr_q <= ptr_q + PTR_W'(1);
                end
            end else if (drain_accept) begin
                o_valid <= 1'b0;
                o_done  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/dc_stream_mc.sv
// Multi-channel DC instruction streamer: NCH independent channels, each fed by its own CSR slice.
// o_state exposes every channel's FSM state, two bits per channel.
module dc_stream_mc
    import dc_stream_pkg::*;
#(
    parameter  int NCH         = 2,
    parameter  int INSN_WIDTH  = 72,
    parameter  int ITER_WIDTH  = 10,
    parameter  int DEPTH       = 20,
    localparam int WPI         = wpi(INSN_WIDTH),
    localparam int REGS_PER_CH = DEPTH * WPI + 2
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic [NCH*REGS_PER_CH*32-1:0] i_regs,
    input  logic [NCH-1:0]              i_abort,
    input  logic [NCH-1:0]              i_ready,
    output logic [NCH-1:0]              o_valid,
    output logic [NCH*INSN_WIDTH-1:0]   o_insn,
    output logic [NCH-1:0]              o_busy,
    output logic [NCH-1:0]              o_done,
    output logic [2*NCH-1:0]            o_state
);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        dc_state_e ch_state;

        dc_stream_chan #(
            .INSN_WIDTH (INSN_WIDTH),
            .ITER_WIDTH (ITER_WIDTH),
            .DEPTH      (DEPTH)
        ) u_chan (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .i_regs  (i_regs[c*REGS_PER_CH*32 +: REGS_PER_CH*32]),
            .i_abort (i_abort[c]),
            .i_ready (i_ready[c]),
            .o_valid (o_valid[c]),
            .o_insn  (o_insn[c*INSN_WIDTH +: INSN_WIDTH]),
            .o_busy  (o_busy[c]),
            .o_done  (o_done[c]),
            .o_state (ch_state)
        );

        assign o_state[2*c +: 2] = ch_state;
    end

endmodule

// File: tb/tb_dc_stream_mc.sv
// Directed bench for dc_stream_mc: a table of single-stream cases plus hand-written multi-cycle sequences.
module tb_dc_stream_mc;

    localparam int NCH   = 2;
    localparam int IW    = 72;
    localparam int DEPTH = 20;
    localparam int WPI   = 3;
    localparam int REGS  = DEPTH * WPI + 2;

    logic                      i_clk;
    logic                      i_rst_n;
    logic [NCH*REGS*32-1:0]    i_regs;
    logic [NCH-1:0]            i_abort;
    logic [NCH-1:0]            i_ready;
    logic [NCH-1:0]            o_valid;
    logic [NCH*IW-1:0]         o_insn;
    logic [NCH-1:0]            o_busy;
    logic [NCH-1:0]            o_done;
    logic [2*NCH-1:0]          o_state;

    int checks = 0;
    int errors = 0;

    dc_stream_mc #(.NCH(NCH), .INSN_WIDTH(IW), .ITER_WIDTH(10), .DEPTH(DEPTH)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_regs  (i_regs),
        .i_abort (i_abort),
        .i_ready (i_ready),
        .o_valid (o_valid),
        .o_insn  (o_insn),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_state (o_state)
    );

    // ---------------- clock / reset ----------------
    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] slot_val(input int ch, input int k, input int gen);
        logic [71:0] v;
        v[71:64] = 8'(8'h5A + gen * 16 + k);
        v[63:32] = 32'(32'hC0DE_0000 + ch * 32'h100 + gen * 32'h1000 + k);
        v[31:0]  = 32'(32'h8000_0000 | (k * 32'h0001_0001) + gen);
        return v;
    endfunction

    function automatic logic [71:0] insn_of(input int ch);
        return o_insn[ch*IW +: IW];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic load_slots(input int ch, input int gen);
        for (int k = 0; k < DEPTH; k++) begin
            int base;
            base = (ch * REGS + k * WPI) * 32;
            i_regs[base +: 72]      = slot_val(ch, k, gen);
            i_regs[base + 72 +: 24] = 24'hFF_FFFF;
        end
    endtask

    task automatic set_ctrl(input int ch, input int mode, input int len, input int iters);
        int base;
        logic [31:0] w;
        base = (ch * REGS + DEPTH * WPI) * 32;
        // Junk in bits outside the iters/len/mode fields must be ignored.
        w = 32'hCFE0_FC00;
        w[9:0]   = 10'(iters);
        w[20:16] = 5'(len);
        w[29:28] = 2'(mode);
        i_regs[base +: 32] = w;
    endtask

    task automatic set_trig(input int ch, input logic [31:0] val);
        i_regs[(ch * REGS + DEPTH * WPI + 1) * 32 +: 32] = val;
    endtask

    // Trigger is driven on a negedge; the first beat is visible on the third negedge after it.
    task automatic start_stream(input int ch, input int mode, input int len, input int iters, input int gen);
        set_trig(ch, 32'd0);
        repeat (3) @(negedge i_clk);
        load_slots(ch, gen);
        set_ctrl(ch, mode, len, iters);
        set_trig(ch, 32'h0000_0100);
    endtask

    task automatic run_stream(input string name, input int ch, input int mode, input int len,
                              input int iters, input int exp_beats);
        int eff_len, beats, dones, first_v, last_b, done_c, other;
        eff_len = (len > DEPTH) ? DEPTH : len;
        beats = 0; dones = 0; first_v = -1; last_b = -1; done_c = -1; other = 0;
        i_ready = '1;
        start_stream(ch, mode, len, iters, 0);
        for (int cyc = 1; cyc <= exp_beats + 10; cyc++) begin
            @(negedge i_clk);
            if (o_valid[1-ch] || o_busy[1-ch] || o_done[1-ch]) other = 1;
            if (o_done[ch]) begin dones++; done_c = cyc; end
            if (o_valid[ch]) begin
                if (first_v < 0) first_v = cyc;
                check({name, "_insn"}, insn_of(ch), slot_val(ch, beats % ((eff_len > 0) ? eff_len : 1), 0));
                beats++;
                last_b = cyc;
            end
        end
        check({name, "_beats"}, 72'(beats), 72'(exp_beats));
        check({name, "_dones"}, 72'(dones), 72'(1));
        check({name, "_other_idle"}, 72'(other), 72'(0));
        if (exp_beats > 0) begin
            check({name, "_first_valid_cyc"}, 72'(first_v), 72'(3));
            check({name, "_done_cyc"}, 72'(done_c), 72'(last_b + 1));
        end else begin
            check({name, "_never_valid"}, 72'(first_v + 1), 72'(0));
            check({name, "_done_cyc"}, 72'(done_c), 72'(2));
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        string name;
        int    ch;
        int    mode;
        int    len;
        int    iters;
        int    exp_beats;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int beats, dones, last_b, done_c, seen, r;
        logic prev_stall;
        logic [71:0] prev_insn;

        vecs[0] = '{"m0_len3_it2",   0, 0, 3,  2, 6};
        vecs[1] = '{"m2_len4_it7",   0, 2, 4,  7, 4};
        vecs[2] = '{"m3_len2_it3",   0, 3, 2,  3, 6};
        vecs[3] = '{"m0_len0",       0, 0, 0,  5, 0};
        vecs[4] = '{"m0_len25_clamp",0, 0, 25, 1, 20};
        vecs[5] = '{"m0_iters0",     0, 0, 3,  0, 0};
        vecs[6] = '{"ch1_m2_len5",   1, 2, 5,  0, 5};
        vecs[7] = '{"ch1_m0_len20",  1, 0, 20, 2, 40};
        vecs[8] = '{"ch1_m3_iters0", 1, 3, 1,  0, 0};
        vecs[9] = '{"m2_len0",       0, 2, 0,  3, 0};

        i_rst_n = 1'b0;
        i_regs  = '0;
        i_abort = '0;
        i_ready = '1;
        repeat (3) @(negedge i_clk);
        check("rst_valid", 72'(o_valid), 72'(0));
        check("rst_busy",  72'(o_busy),  72'(0));
        check("rst_done",  72'(o_done),  72'(0));
        check("rst_insn",  72'(o_insn),  72'(0));
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);

        // Asynchronous reset in the middle of a looping stream.
        start_stream(0, 1, 2, 0, 0);
        repeat (6) @(negedge i_clk);
        check("arst_pre_valid", 72'(o_valid[0]), 72'(1));
        #2 i_rst_n = 1'b0;
        #1;
        check("arst_valid", 72'(o_valid), 72'(0));
        check("arst_busy",  72'(o_busy),  72'(0));
        check("arst_done",  72'(o_done),  72'(0));
        @(negedge i_clk);
        i_rst_n = 1'b1;
        seen = 0;
        repeat (10) begin
            @(negedge i_clk);
            if (o_valid != '0 || o_done != '0) seen = 1;
        end
        check("arst_no_restart", 72'(seen), 72'(0));
        set_trig(0, 32'd0);

        for (int i = 0; i < 10; i++)
            run_stream(vecs[i].name, vecs[i].ch, vecs[i].mode, vecs[i].len, vecs[i].iters, vecs[i].exp_beats);
        set_trig(1, 32'd0);

        // Backpressure: four beats in order, held stable while stalled.
        start_stream(0, 0, 4, 1, 0);
        beats = 0; dones = 0; last_b = -1; done_c = -1; prev_stall = 1'b0; prev_insn = '0;
        for (int cyc = 1; cyc <= 200 && done_c < 0; cyc++) begin
            @(negedge i_clk);
            if (prev_stall) begin
                check("bp_hold_valid", 72'(o_valid[0]), 72'(1));
                check("bp_hold_insn", insn_of(0), prev_insn);
            end
            if (o_done[0]) begin dones++; done_c = cyc; end
            r = int'($urandom_range(0, 1));
            i_ready[0] = r[0];
            if (o_valid[0] && r[0]) begin
                check("bp_beat", insn_of(0), slot_val(0, beats, 0));
                beats++;
                last_b = cyc;
            end
            prev_stall = o_valid[0] & ~r[0];
            prev_insn  = insn_of(0);
        end
        i_ready = '1;
        check("bp_beats", 72'(beats), 72'(4));
        check("bp_done_cyc", 72'(done_c), 72'(last_b + 1));

        // Trigger left nonzero after completion must not start another load.
        seen = 0;
        repeat (20) begin
            @(negedge i_clk);
            if (o_valid[0] || o_done[0] || o_busy[0]) seen = 1;
        end
        check("hold_trig_one_load", 72'(seen), 72'(0));

        // Mode 1 forever, then abort.
        start_stream(0, 1, 2, 9, 0);
        beats = 0; dones = 0;
        for (int cyc = 1; cyc <= 100 && beats < 50; cyc++) begin
            @(negedge i_clk);
            if (o_done[0]) dones++;
            if (o_valid[0]) begin
                check("loop_insn", insn_of(0), slot_val(0, beats % 2, 0));
                beats++;
            end
        end
        check("loop_beats", 72'(beats), 72'(50));
        i_abort[0] = 1'b1;
        @(negedge i_clk);
        i_abort[0] = 1'b0;
        check("abort_valid", 72'(o_valid[0]), 72'(0));
        check("abort_busy",  72'(o_busy[0]),  72'(0));
        check("abort_state", 72'(o_state[1:0]), 72'(0));
        repeat (10) begin
            @(negedge i_clk);
            if (o_done[0] || o_valid[0]) dones++;
        end
        check("abort_no_done", 72'(dones), 72'(0));

        // Reload mid-run: trigger 1 -> 0 -> 1, buffer holds old slots until capture.
        start_stream(0, 1, 3, 0, 0);
        repeat (6) @(negedge i_clk);
        load_slots(0, 1);
        set_trig(0, 32'd0);
        @(negedge i_clk);
        set_trig(0, 32'd7);
        @(negedge i_clk);
        check("reload_still_valid", 72'(o_valid[0]), 72'(1));
        check("reload_old_data", 72'(insn_of(0) == slot_val(0, 0, 1)), 72'(0));
        @(negedge i_clk);
        check("reload_gap_valid", 72'(o_valid[0]), 72'(0));
        check("reload_gap_state", 72'(o_state[1:0]), 72'(1));
        @(negedge i_clk);
        check("reload_s0_valid", 72'(o_valid[0]), 72'(1));
        check("reload_s0", insn_of(0), slot_val(0, 0, 1));
        @(negedge i_clk);
        check("reload_s1", insn_of(0), slot_val(0, 1, 1));

        // Abort in the same cycle as new_stream: the reload wins.
        load_slots(0, 2);
        set_trig(0, 32'd0);
        @(negedge i_clk);
        set_trig(0, 32'd3);
        @(negedge i_clk);
        i_abort[0] = 1'b1;
        @(negedge i_clk);
        i_abort[0] = 1'b0;
        check("abort_reload_valid", 72'(o_valid[0]), 72'(0));
        check("abort_reload_busy",  72'(o_busy[0]),  72'(1));
        @(negedge i_clk);
        check("abort_reload_s0_valid", 72'(o_valid[0]), 72'(1));
        check("abort_reload_s0", insn_of(0), slot_val(0, 0, 2));
        i_abort[0] = 1'b1;
        @(negedge i_clk);
        i_abort[0] = 1'b0;
        check("final_abort_busy", 72'(o_busy[0]), 72'(0));
        set_trig(0, 32'd0);
        repeat (3) @(negedge i_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
